// File: rtl/game_status_pkg.sv
// Shared constants, state type and frame helpers for the game status SPI port.
package game_status_pkg;

  localparam logic [2:0]  HDR     = 3'b101;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

  // Frame bit positions, MSB shifted first.
  localparam int unsigned HdrMsb      = 15;
  localparam int unsigned HdrLsb      = 13;
  localparam int unsigned LifeLostBit = 12;
  localparam int unsigned LevelUpBit  = 11;
  localparam int unsigned WinBit      = 10;
  localparam int unsigned LifeMsb     = 9;
  localparam int unsigned LifeLsb     = 7;
  localparam int unsigned LevelMsb    = 6;
  localparam int unsigned LevelLsb    = 5;
  localparam int unsigned KeyMsb      = 4;
  localparam int unsigned KeyLsb      = 1;
  localparam int unsigned ParityBit   = 0;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StHold
  } state_e;

  // Parity bit that makes the full frame carry an even number of ones.
  function automatic logic even_parity(input logic [FRAME_W-2:0] body);
    return ^body;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI line, plus registered
// rise/fall pulse detection on the synchronised level.
module spi_sync_edge #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
      prev_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/game_status_spi.sv
// SPI-slave (mode 0, MSB first) status port: streams a 16-bit game snapshot to the
// MCU, captures a 16-bit command word and keeps sticky life-lost / level-up flags.
module game_status_spi
  import game_status_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               win,
  input  logic [2:0]         total_life,
  input  logic [1:0]         level,
  input  logic [3:0]         key_out,
  input  logic               sck,
  input  logic               cs_n,
  input  logic               mosi,
  output logic               miso,
  output logic               cmd_valid,
  output logic [FRAME_W-1:0] cmd_data
);

  logic sck_q, sck_rise, sck_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync_edge #(.ResetVal(1'b0)) u_sync_sck (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (sck),
    .q_o     (sck_q),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  spi_sync_edge #(.ResetVal(1'b1)) u_sync_cs (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (cs_n),
    .q_o     (cs_q),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  spi_sync_edge #(.ResetVal(1'b0)) u_sync_mosi (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (mosi),
    .q_o     (mosi_q),
    .rise_o  (mosi_rise),
    .fall_o  (mosi_fall)
  );

  assign unused_sync = ^{sck_q, cs_q, mosi_rise, mosi_fall};

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] tx_shift_q, tx_shift_d;
  logic [FRAME_W-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_W-1:0] cmd_data_q, cmd_data_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [1:0]         snap_flags_q, snap_flags_d;
  logic [2:0]         life_prev_q;
  logic [1:0]         level_prev_q;
  logic               life_lost_q, life_lost_d;
  logic               level_up_q, level_up_d;
  logic               life_event, level_event;
  logic               clr_life, clr_level;
  logic [FRAME_W-2:0] frame_body;
  logic [FRAME_W-1:0] frame;

  // A 0 -> 7 wrap of total_life compares as an increase, so it never sets the flag.
  assign life_event  = total_life < life_prev_q;
  assign level_event = level > level_prev_q;

  assign frame_body = {HDR, life_lost_q, level_up_q, win, total_life, level, key_out};
  assign frame      = {frame_body, even_parity(frame_body)};

  always_comb begin
    state_d      = state_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    cmd_data_d   = cmd_data_q;
    cmd_valid_d  = 1'b0;
    bit_cnt_d    = bit_cnt_q;
    snap_flags_d = snap_flags_q;
    clr_life     = 1'b0;
    clr_level    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          tx_shift_d   = frame;
          snap_flags_d = {life_lost_q, level_up_q};
          bit_cnt_d    = '0;
          state_d      = StShift;
        end
      end
      StShift: begin
        if (cs_rise) begin
          // Aborted frame: command and flags left untouched.
          state_d = StIdle;
        end else begin
          if (sck_rise) begin
            rx_shift_d = {rx_shift_q[FRAME_W-2:0], mosi_q};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
              cmd_data_d  = {rx_shift_q[FRAME_W-2:0], mosi_q};
              cmd_valid_d = 1'b1;
              state_d     = StHold;
            end
          end
          if (sck_fall) begin
            tx_shift_d = {tx_shift_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      StHold: begin
        if (cs_rise) begin
          clr_life  = snap_flags_q[1];
          clr_level = snap_flags_q[0];
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new event in the clearing clock keeps the flag set.
    life_lost_d = (life_lost_q & ~clr_life) | life_event;
    level_up_d  = (level_up_q & ~clr_level) | level_event;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      cmd_data_q   <= '0;
      cmd_valid_q  <= 1'b0;
      bit_cnt_q    <= '0;
      snap_flags_q <= '0;
      life_prev_q  <= 3'b111;
      level_prev_q <= 2'b00;
      life_lost_q  <= 1'b0;
      level_up_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      cmd_data_q   <= cmd_data_d;
      cmd_valid_q  <= cmd_valid_d;
      bit_cnt_q    <= bit_cnt_d;
      snap_flags_q <= snap_flags_d;
      life_prev_q  <= total_life;
      level_prev_q <= level;
      life_lost_q  <= life_lost_d;
      level_up_q   <= level_up_d;
    end
  end

  assign miso      = (state_q == StShift) & tx_shift_q[FRAME_W-1];
  assign cmd_valid = cmd_valid_q;
  assign cmd_data  = cmd_data_q;

endmodule

// File: tb/tb_game_status_spi.sv
// Self-checking bench for game_status_spi: an SPI master model with a scoreboard of
// expected frames and command words.
module tb_game_status_spi;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        win = 1'b0;
  logic [2:0]  total_life = 3'd7;
  logic [1:0]  level = 2'd0;
  logic [3:0]  key_out = 4'h3;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        cmd_valid;
  logic [15:0] cmd_data;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  logic [15:0] frame_q[$];
  logic [15:0] cmd_q[$];

  game_status_spi dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .win        (win),
    .total_life (total_life),
    .level      (level),
    .key_out    (key_out),
    .sck        (sck),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data)
  );

  always #5 clk = ~clk;

  // Counts clocks with cmd_valid high, so a stretched pulse counts more than once.
  always @(negedge clk) if (cmd_valid === 1'b1) pulse_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] model_frame(input bit ll, input bit lu, input bit w,
                                              input logic [2:0] life, input logic [1:0] lv,
                                              input logic [3:0] key);
    logic [15:0] f;
    int ones;
    f = {3'b101, ll, lu, w, life, lv, key, 1'b0};
    ones = 0;
    for (int i = 1; i < 16; i++) ones += int'(f[i]);
    f[0] = (ones % 2) == 1;
    return f;
  endfunction

  // Mode-0 master: sample miso just before each sck rise, change mosi after each fall.
  task automatic run_frame(input logic [15:0] tx, input int nbits, input bit collide,
                           output logic [15:0] rx, output int pulses);
    int p0;
    p0 = pulse_cnt;
    rx = '0;
    @(posedge clk); #1 cs_n = 1'b0; mosi = tx[15];
    repeat (8) @(posedge clk);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 rx = {rx[14:0], miso}; sck = 1'b1;
      repeat (8) @(posedge clk);
      #1 sck = 1'b0;
      if (i < 15) mosi = tx[14-i];
      repeat (7) @(posedge clk);
    end
    repeat (4) @(posedge clk);
    #1 cs_n = 1'b1;
    if (collide) begin
      // Lower total_life for exactly the clock in which the flag clear lands.
      @(posedge clk); @(posedge clk); #1 total_life = total_life - 3'd1;
      @(posedge clk); #1 total_life = total_life + 3'd1;
    end
    repeat (8) @(posedge clk);
    #1 mosi = 1'b0;
    pulses = pulse_cnt - p0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (miso !== 1'b0) begin n_err++; $display("FAIL reset_miso got=%b want=0", miso); end
    n_vec++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset_cmd_valid got=%b want=0", cmd_valid); end
    n_vec++; if (cmd_data !== 16'h0) begin n_err++; $display("FAIL reset_cmd_data got=%h want=0000", cmd_data); end
    @(negedge clk) reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_vec++; if (miso !== 1'b0) begin n_err++; $display("FAIL idle_miso got=%b want=0", miso); end
    n_vec++; if (pulse_cnt !== 0) begin n_err++; $display("FAIL idle_pulses got=%0d want=0", pulse_cnt); end
  endtask

  task automatic test_basic_frame();
    logic [15:0] rx, exp_f, exp_c;
    int p;
    frame_q.push_back(model_frame(0, 0, 0, 3'd7, 2'd0, 4'h3));
    cmd_q.push_back(16'hC35A);
    run_frame(16'hC35A, 16, 0, rx, p);
    exp_f = frame_q.pop_front();
    exp_c = cmd_q.pop_front();
    n_vec++; if (rx !== exp_f) begin n_err++; $display("FAIL basic_frame got=%h want=%h", rx, exp_f); end
    n_vec++; if (p !== 1) begin n_err++; $display("FAIL basic_pulses got=%0d want=1", p); end
    n_vec++; if (cmd_data !== exp_c) begin n_err++; $display("FAIL basic_cmd got=%h want=%h", cmd_data, exp_c); end
    repeat (30) @(posedge clk);
    #1;
    n_vec++; if (cmd_data !== exp_c) begin n_err++; $display("FAIL cmd_held got=%h want=%h", cmd_data, exp_c); end
    n_vec++; if (miso !== 1'b0) begin n_err++; $display("FAIL idle_miso2 got=%b want=0", miso); end
  endtask

  task automatic test_sticky();
    logic [15:0] rx, exp_f, exp_c;
    int p;
    total_life = 3'd6;
    level = 2'd1;
    repeat (5) @(posedge clk);
    frame_q.push_back(model_frame(1, 1, 0, 3'd6, 2'd1, 4'h3));
    frame_q.push_back(model_frame(0, 0, 0, 3'd6, 2'd1, 4'h3));
    cmd_q.push_back(16'h1234);
    cmd_q.push_back(16'hBEEF);
    for (int k = 0; k < 2; k++) begin
      run_frame(cmd_q[0], 16, 0, rx, p);
      exp_f = frame_q.pop_front();
      exp_c = cmd_q.pop_front();
      n_vec++; if (rx !== exp_f) begin n_err++; $display("FAIL sticky_frame%0d got=%h want=%h", k, rx, exp_f); end
      n_vec++; if (p !== 1) begin n_err++; $display("FAIL sticky_pulses%0d got=%0d want=1", k, p); end
      n_vec++; if (cmd_data !== exp_c) begin n_err++; $display("FAIL sticky_cmd%0d got=%h want=%h", k, cmd_data, exp_c); end
    end
  endtask

  task automatic test_abort();
    logic [15:0] rx, exp_f, exp_c;
    int p;
    total_life = 3'd5;
    level = 2'd2;
    repeat (5) @(posedge clk);
    run_frame(16'hFFFF, 9, 0, rx, p);
    #1;
    n_vec++; if (p !== 0) begin n_err++; $display("FAIL abort_pulses got=%0d want=0", p); end
    n_vec++; if (cmd_data !== 16'hBEEF) begin n_err++; $display("FAIL abort_cmd got=%h want=beef", cmd_data); end
    n_vec++; if (miso !== 1'b0) begin n_err++; $display("FAIL abort_miso got=%b want=0", miso); end
    frame_q.push_back(model_frame(1, 1, 0, 3'd5, 2'd2, 4'h3));
    cmd_q.push_back(16'h0F0F);
    run_frame(16'h0F0F, 16, 0, rx, p);
    exp_f = frame_q.pop_front();
    exp_c = cmd_q.pop_front();
    n_vec++; if (rx !== exp_f) begin n_err++; $display("FAIL after_abort_frame got=%h want=%h", rx, exp_f); end
    n_vec++; if (cmd_data !== exp_c) begin n_err++; $display("FAIL after_abort_cmd got=%h want=%h", cmd_data, exp_c); end
  endtask

  task automatic test_clear_collision();
    logic [15:0] rx, exp_f;
    int p;
    total_life = 3'd4;
    repeat (5) @(posedge clk);
    frame_q.push_back(model_frame(1, 0, 0, 3'd4, 2'd2, 4'h3));
    frame_q.push_back(model_frame(1, 0, 0, 3'd4, 2'd2, 4'h3));
    frame_q.push_back(model_frame(0, 0, 0, 3'd4, 2'd2, 4'h3));
    for (int k = 0; k < 3; k++) begin
      run_frame(16'h00A5 + 16'(k), 16, k == 0, rx, p);
      exp_f = frame_q.pop_front();
      n_vec++; if (rx !== exp_f) begin n_err++; $display("FAIL collide_frame%0d got=%h want=%h", k, rx, exp_f); end
    end
    n_vec++; if (cmd_data !== 16'h00A7) begin n_err++; $display("FAIL collide_cmd got=%h want=00a7", cmd_data); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] rx, exp_f, exp_c;
    int p, p0;
    total_life = 3'd2;
    repeat (5) @(posedge clk);
    p0 = pulse_cnt;
    @(posedge clk); #1 cs_n = 1'b0; mosi = 1'b1;
    repeat (8) @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1 sck = 1'b1;
      repeat (8) @(posedge clk);
      #1 sck = 1'b0;
      repeat (7) @(posedge clk);
    end
    @(posedge clk); #1 sck = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_vec++; if (miso !== 1'b0) begin n_err++; $display("FAIL midreset_miso got=%b want=0", miso); end
    n_vec++; if (cmd_data !== 16'h0) begin n_err++; $display("FAIL midreset_cmd got=%h want=0000", cmd_data); end
    sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    total_life = 3'd7; level = 2'd0; win = 1'b1; key_out = 4'hA;
    repeat (4) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_vec++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("FAIL midreset_pulses got=%0d want=0", pulse_cnt - p0); end
    n_vec++; if (miso !== 1'b0) begin n_err++; $display("FAIL postreset_miso got=%b want=0", miso); end
    frame_q.push_back(model_frame(0, 0, 1, 3'd7, 2'd0, 4'hA));
    cmd_q.push_back(16'h5AA5);
    run_frame(16'h5AA5, 16, 0, rx, p);
    exp_f = frame_q.pop_front();
    exp_c = cmd_q.pop_front();
    n_vec++; if (rx !== exp_f) begin n_err++; $display("FAIL postreset_frame got=%h want=%h", rx, exp_f); end
    n_vec++; if (p !== 1) begin n_err++; $display("FAIL postreset_pulses got=%0d want=1", p); end
    n_vec++; if (cmd_data !== exp_c) begin n_err++; $display("FAIL postreset_cmd got=%h want=%h", cmd_data, exp_c); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_sticky();
    test_abort();
    test_clear_collision();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
